// File: rtl/dii_package.sv
// Shared DII flit type used by every debug module and the ring/router ports.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_rr_select.sv
// Combinational round-robin first-valid search.
// Scans req starting at ptr, ptr+1, ... (mod N) and reports the first set index.
module osd_rr_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand_idx [N];
    logic [N-1:0]  cand_req;

    // Candidate gi is the index reached after gi steps from ptr, wrapped at N
    // (N need not be a power of two, so a plain bit-width wrap is not enough).
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum           = {1'b0, ptr} + (IW+1)'(gi);
        assign cand_idx[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
        assign cand_req[gi]  = req[cand_idx[gi]];
    end

    // Lowest offset from ptr wins: scan from the far end so nearer hits overwrite.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                gnt_idx = cand_idx[k];
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_dii_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing one DII output among N debug
// modules. The output stays locked to one source from first flit to last;
// packets longer than MAX_PKT_LEN are cut (last forced) and their tail dropped.
module osd_dii_pkt_arbiter
    import dii_package::*;
#(
    parameter int N           = 4,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  dii_flit              in_flit [N],
    output logic [N-1:0]         in_ready,
    output dii_flit              out_flit,
    input  logic                 out_ready,
    output logic                 err_overlen,
    output logic [$clog2(N)-1:0] err_src
);

    localparam int GW = $clog2(N);
    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCK,
        S_DROP
    } state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            err_overlen_reg, err_overlen_next;
    logic [GW-1:0]   err_src_reg, err_src_next;

    logic [N-1:0]    req;
    logic [GW-1:0]   rr_gnt;
    logic            rr_any;
    dii_flit         sel_flit;
    logic            at_limit;

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign req[gi] = in_flit[gi].valid;
    end

    osd_rr_select #(
        .N (N)
    ) u_rr_select (
        .req     (req),
        .ptr     (rr_ptr_reg),
        .gnt_idx (rr_gnt),
        .any     (rr_any)
    );

    assign sel_flit    = in_flit[grant_reg];
    // The flit currently offered is the MAX_PKT_LEN-th of the packet.
    assign at_limit    = (cnt_reg == CNT_LAST);
    assign err_overlen = err_overlen_reg;
    assign err_src     = err_src_reg;

    // State and bookkeeping registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            grant_reg       <= '0;
            rr_ptr_reg      <= '0;
            cnt_reg         <= '0;
            err_overlen_reg <= 1'b0;
            err_src_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            rr_ptr_reg      <= rr_ptr_next;
            cnt_reg         <= cnt_next;
            err_overlen_reg <= err_overlen_next;
            err_src_reg     <= err_src_next;
        end
    end

    // Next-state logic plus the combinational output mux / ready steering.
    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        rr_ptr_next      = rr_ptr_reg;
        cnt_next         = cnt_reg;
        err_overlen_next = 1'b0;
        err_src_next     = err_src_reg;
        out_flit         = '0;
        in_ready         = '0;

        case (state_reg)
            S_IDLE: begin
                // One bubble cycle: pick a winner, forward nothing yet.
                if (rr_any) begin
                    grant_next  = rr_gnt;
                    rr_ptr_next = (rr_gnt == GW'(N - 1)) ? '0 : rr_gnt + 1'b1;
                    cnt_next    = '0;
                    state_next  = S_LOCK;
                end
            end

            S_LOCK: begin
                in_ready[grant_reg] = out_ready;
                if (sel_flit.valid) begin
                    out_flit = sel_flit;
                    if (at_limit) begin
                        out_flit.last = 1'b1;
                    end
                end
                if (sel_flit.valid && out_ready) begin
                    if (!at_limit) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                    if (sel_flit.last) begin
                        // A genuine last on the final allowed flit is not an error.
                        state_next = S_IDLE;
                    end else if (at_limit) begin
                        err_overlen_next = 1'b1;
                        err_src_next     = grant_reg;
                        state_next       = S_DROP;
                    end
                end
            end

            S_DROP: begin
                // Swallow the rest of the overlong packet so the source unblocks.
                in_ready[grant_reg] = 1'b1;
                if (sel_flit.valid && sel_flit.last) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_osd_dii_pkt_arbiter.sv
// Scoreboard bench for osd_dii_pkt_arbiter (N=4, MAX_PKT_LEN=8).
module tb_osd_dii_pkt_arbiter;
    import dii_package::*;

    localparam int N       = 4;
    localparam int MAX_LEN = 8;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          src;
    } sb_item_t;

    logic          clk;
    logic          rst;
    dii_flit       in_flit [N];
    logic [N-1:0]  in_ready;
    dii_flit       out_flit;
    logic          out_ready;
    logic          err_overlen;
    logic [1:0]    err_src;

    dii_flit       srcq [N][$];
    sb_item_t      sb [$];
    logic          vtrace [$];
    logic [N-1:0]  acc;
    int            checks;
    int            errors;
    int            err_pulses;
    int            exp_err_src;
    bit            bp_mode;

    osd_dii_pkt_arbiter #(
        .N           (N),
        .MAX_PKT_LEN (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_ready   (out_ready),
        .err_overlen (err_overlen),
        .err_src     (err_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Queue a packet at a source and record what the output should show.
    task automatic send_pkt(input int src, input int len, input logic [15:0] base);
        dii_flit  f;
        sb_item_t e;
        for (int k = 0; k < len; k++) begin
            f.valid = 1'b1;
            f.data  = base + 16'(k);
            f.last  = (k == len - 1);
            srcq[src].push_back(f);
            if (k < MAX_LEN) begin
                e.data = f.data;
                e.last = f.last || (k == MAX_LEN - 1);
                e.src  = src;
                sb.push_back(e);
            end
        end
    endtask

    // One clock: drive at posedge+1, sample at posedge+2, retire accepted flits.
    task automatic cycle();
        sb_item_t e;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) in_flit[i] = srcq[i][0];
            else                    in_flit[i] = '0;
        end
        out_ready = bp_mode ? ~out_ready : 1'b1;
        #1;
        vtrace.push_back(out_flit.valid);
        if (err_overlen) begin
            err_pulses++;
            chk("err_src", 32'(err_src), 32'(exp_err_src));
        end
        if (out_flit.valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(out_flit.valid), 32'd0);
            end else begin
                e = sb[0];
                chk("data", 32'(out_flit.data), 32'(e.data));
                chk("last", 32'(out_flit.last), 32'(e.last));
                chk("in_ready", 32'(in_ready), out_ready ? (32'd1 << e.src) : 32'd0);
                if (out_ready) void'(sb.pop_front());
            end
        end else begin
            chk("idle_zero", 32'(out_flit), 32'd0);
        end
        for (int i = 0; i < N; i++) acc[i] = in_flit[i].valid && in_ready[i];
        @(posedge clk);
        for (int i = 0; i < N; i++) if (acc[i]) void'(srcq[i].pop_front());
        #1;
    endtask

    function automatic int pending();
        int p = sb.size();
        for (int i = 0; i < N; i++) p += srcq[i].size();
        return p;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_pending", 32'(pending()), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        bp_mode   = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_flit[i] = '0;
            srcq[i].delete();
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vtrace.delete();
        err_pulses = 0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        err_pulses  = 0;
        exp_err_src = 0;
        bp_mode     = 1'b0;
        out_ready   = 1'b1;
        rst         = 1'b1;
        for (int i = 0; i < N; i++) in_flit[i] = '0;

        // Reset state
        do_reset();
        #1;
        chk("rst_out_flit", 32'(out_flit), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_err_overlen", 32'(err_overlen), 32'd0);
        chk("rst_err_src", 32'(err_src), 32'd0);
        @(posedge clk);
        #1;

        // Single source: bubble then three flits
        send_pkt(2, 3, 16'h0001);
        drain(50);
        chk("single_trace_len", 32'(vtrace.size()), 32'd4);
        for (int k = 0; k < vtrace.size(); k++)
            chk($sformatf("single_trace%0d", k), 32'(vtrace[k]), 32'(k >= 1 && k <= 3));

        // Fairness: all sources, two 2-flit packets each
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++)
                send_pkt(s, 2, 16'(s * 16'h1000 + p * 16'h0100));
        drain(200);
        chk("fair_trace_len", 32'(vtrace.size()), 32'd24);
        for (int k = 0; k < vtrace.size(); k++)
            chk($sformatf("fair_trace%0d", k), 32'(vtrace[k]), 32'(k % 3 != 0));

        // Backpressure: out_ready toggles every cycle
        do_reset();
        bp_mode = 1'b1;
        send_pkt(1, 4, 16'h1a00);
        drain(100);
        bp_mode = 1'b0;

        // Overlength: 11 flits from src3, others queue up during the packet
        do_reset();
        exp_err_src = 3;
        send_pkt(3, 11, 16'h3000);
        repeat (5) cycle();
        send_pkt(0, 2, 16'h0100);
        send_pkt(2, 2, 16'h2100);
        drain(200);
        chk("overlen_pulses", 32'(err_pulses), 32'd1);
        chk("overlen_src_held", 32'(err_src), 32'd3);

        // Exact maximum: genuine last on flit 8
        do_reset();
        send_pkt(0, MAX_LEN, 16'h0800);
        drain(100);
        chk("exact_pulses", 32'(err_pulses), 32'd0);
        chk("exact_trace_len", 32'(vtrace.size()), 32'(MAX_LEN + 1));

        // Reset mid-packet after 2 of 5 flits from src1
        do_reset();
        send_pkt(1, 5, 16'h1500);
        repeat (3) cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_flit", 32'(out_flit), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_err", 32'(err_overlen), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        sb.delete();
        vtrace.delete();
        // rr_ptr back at 0 means src1 beats src3 even though src1 went last
        send_pkt(1, 2, 16'h1600);
        send_pkt(3, 2, 16'h3600);
        drain(100);
        chk("midrst_bubble", 32'(vtrace[0]), 32'd0);
        chk("midrst_first", 32'(vtrace[1]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
